// File: rtl/nor_stim_pkg.sv
// ----------------------------------------------------------------------------
// nor_stim_pkg
// Shared definitions for the NOR gate stimulus generator:
//   state_e       FSM state encoding (IDLE / RUN / DONE)
//   NUM_VEC       number of stimulus vectors per run
//   VEC_IDX_W     width of the vector index
//   ERR_W         width of the mismatch counter
//   nor_expected  ideal NOR response for a given vector index
// ----------------------------------------------------------------------------
package nor_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NUM_VEC   = 4;
    localparam int VEC_IDX_W = 2;
    localparam int ERR_W     = 3;

    typedef logic [VEC_IDX_W-1:0] vec_idx_t;
    typedef logic [ERR_W-1:0]     err_cnt_t;

    localparam vec_idx_t LAST_VEC = vec_idx_t'(NUM_VEC - 1);

    // The vector index doubles as {din_a, din_b}, so the ideal gate output
    // is simply the NOR of its two bits.
    function automatic logic nor_expected(input vec_idx_t vec);
        return ~(vec[1] | vec[0]);
    endfunction

endpackage : nor_stim_pkg

// File: rtl/nor_stim_gen_hold_timer.sv
// ----------------------------------------------------------------------------
// hold_timer
// Loadable down-counter that measures how long each stimulus vector is held.
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset (count cleared to 0)
//   load_i        load load_val_i into the counter (wins over en_i)
//   en_i          decrement enable; the count stops at 0
//   load_val_i    value to load (caller guarantees >= 1)
//   last_cycle_o  high while the count equals 1, i.e. the final hold cycle
// ----------------------------------------------------------------------------
module hold_timer #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [HOLD_W-1:0] load_val_i,
    output logic              last_cycle_o
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;

    // NOTE: combinational blocks assign a default to every output first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_cycle_o = (cnt_q == HOLD_W'(1));

endmodule : hold_timer

// File: rtl/nor_stim_gen.sv
// ----------------------------------------------------------------------------
// nor_stim_gen
// Drives the four input combinations 00, 01, 10, 11 into an external NOR gate,
// holds each for N = max(hold_cycles, 1) cycles, checks the returned gate
// output on the last cycle of each vector and reports the mismatch count.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset; aborts a run without done
//   start        run request, only accepted in IDLE
//   hold_cycles  cycles per vector, latched at start (0 treated as 1)
//   din_a/din_b  registered stimulus to the gate (0 outside RUN)
//   dout_in      gate output returned from the device under stimulus
//   busy         high while vectors are being driven
//   done         one-cycle pulse after the last vector was checked
//   err_cnt      mismatches seen in the current / last run (0..4)
//   pass         high when the last completed run had no mismatches
// ----------------------------------------------------------------------------
module nor_stim_gen
    import nor_stim_pkg::*;
#(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              din_a,
    output logic              din_b,
    input  logic              dout_in,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              pass
);

    state_e            state_q, state_d;
    vec_idx_t          vec_q,   vec_d;
    err_cnt_t          err_q,   err_d;
    logic              pass_q,  pass_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;

    logic              tmr_load;
    logic [HOLD_W-1:0] tmr_val;
    logic              tmr_last;
    logic [HOLD_W-1:0] hold_eff;

    assign hold_eff = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;

    hold_timer #(
        .HOLD_W (HOLD_W)
    ) u_hold_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (tmr_load),
        .en_i         (state_q == RUN),
        .load_val_i   (tmr_val),
        .last_cycle_o (tmr_last)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        pass_d   = pass_q;
        hold_d   = hold_q;
        tmr_load = 1'b0;
        tmr_val  = hold_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    vec_d    = '0;
                    err_d    = '0;
                    pass_d   = 1'b0;
                    hold_d   = hold_eff;
                    tmr_load = 1'b1;
                    tmr_val  = hold_eff;
                end
            end

            RUN: begin
                // The gate response is judged only on the final hold cycle,
                // giving the downstream path N-1 cycles to settle.
                if (tmr_last) begin
                    if (dout_in != nor_expected(vec_q)) begin
                        err_d = err_q + err_cnt_t'(1);
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        vec_d   = '0;
                        pass_d  = (err_d == '0);
                    end else begin
                        vec_d    = vec_q + vec_idx_t'(1);
                        tmr_load = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: every control and result register is reset; there is no memory
    // array here, so nothing is left to power up undefined.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            hold_q  <= hold_d;
        end
    end

    // The vector index register is the stimulus itself and is forced to 00
    // whenever the FSM leaves RUN, so the outputs are glitch-free flops.
    assign din_a   = vec_q[1];
    assign din_b   = vec_q[0];
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign err_cnt = err_q;
    assign pass    = pass_q;

endmodule : nor_stim_gen

// File: doc/nor_stim_gen.md
NOR_STIM_GEN -- requirements
Module: nor_stim_gen

Interface
REQ-001 Parameter: HOLD_W, default 4, width of hold_cycles.
REQ-002 Ports: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Ports: rst  input  1  synchronous, active-high reset.
REQ-004 Ports: start  input  1  run request, sampled at rising edge in IDLE only.
REQ-005 Ports: hold_cycles  input  HOLD_W  cycles each vector is held; latched at start; 0 treated as 1.
REQ-006 Ports: din_a  output  1  registered stimulus to downstream NOR gate input a.
REQ-007 Ports: din_b  output  1  registered stimulus to downstream NOR gate input b.
REQ-008 Ports: dout_in  input  1  gate result returned from downstream NOR gate dout.
REQ-009 Ports: busy  output  1  high in RUN.
REQ-010 Ports: done  output  1  one-cycle pulse at end of run.
REQ-011 Ports: err_cnt  output  3  mismatches in the last run, range 0..4.
REQ-012 Ports: pass  output  1  high when the last completed run had err_cnt==0.
REQ-013 One clock; reset is synchronous and active-high; clock port named clk, reset port named rst.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after last vector sampled; DONE->IDLE unconditionally after one cycle.
REQ-015 Vector order fixed: (din_a,din_b) = 00, 01, 10, 11; vector index 2 bits, no wrap beyond 11.
REQ-016 On the IDLE->RUN edge: N = max(hold_cycles,1) latched, din=00 registered, err_cnt and pass cleared.
REQ-017 Each vector driven for exactly N cycles; dout_in sampled at the rising edge ending the vector's last cycle.
REQ-018 Expected value = NOT(din_a OR din_b) of the currently driven vector; mismatch increments err_cnt by 1.
REQ-019 start high in cycle k: vector 00 visible cycle k+1; done high in cycle k+4N+1; busy high cycles k+1..k+4N.
REQ-020 In DONE: done=1, din_a=din_b=0, err_cnt final including last vector, pass = (err_cnt==0).
REQ-021 err_cnt and pass hold their values in IDLE until the next accepted start.
REQ-022 start while in RUN or DONE is ignored; no restart, no effect on hold latch.
REQ-023 hold_cycles changes during RUN have no effect.
REQ-024 din_a, din_b are 0 in IDLE and DONE.

Reset
REQ-025 rst high at a rising edge: state IDLE, din_a=din_b=0, busy=0, done=0, err_cnt=0, pass=0, hold counter and vector index 0.
REQ-026 rst overrides start in the same cycle; rst mid-run aborts with no done pulse.

Structure
REQ-027 Shared package nor_stim_pkg: state encoding constants (IDLE/RUN/DONE), NUM_VEC=4, vector index width 2, err_cnt width 3.
REQ-028 One sub-module hold_timer: loadable down-counter of width HOLD_W, asserting last_cycle when the count reaches 1.

Verification
REQ-029 rst then start, hold_cycles=1, dout_in from ideal NOR -> din 00,01,10,11 in cycles k+1..k+4; done in k+5; err_cnt=0; pass=1.
REQ-030 hold_cycles=3, ideal NOR -> each vector held 3 cycles; done in k+13; pass=1.
REQ-031 dout_in stuck at 0 -> err_cnt=1 (vector 00 only); pass=0.
REQ-032 dout_in stuck at 1 -> err_cnt=3; pass=0.
REQ-033 rst during vector 10 -> next cycle IDLE, din=00, busy=0, err_cnt=0; no done pulse.
REQ-034 hold_cycles=0 with start pulsed again in cycle k+2 -> behaves as N=1; second start ignored; exactly one done in k+5.
